// File: rtl/press_game_core_if.sv
// press_game_core_if: sprite draw command handshake between the game core (master) and the drawer (slave).
interface press_game_core_if #(
    parameter int LANE_W = 2
);
    logic              draw_req;
    logic [LANE_W-1:0] draw_pos;
    logic              draw_item;
    logic              draw_erase;
    logic              draw_ack;
    modport master (output draw_req, draw_pos, draw_item, draw_erase, input draw_ack);
    modport slave (input draw_req, draw_pos, draw_item, draw_erase, output draw_ack);
endinterface

// File: rtl/press_game_core.sv
// press_game_core: press sweep, garbage spawn/expiry, hit/miss scoring and serialized draw commands.
// Define SCORE_BCD_EN for packed-BCD score/miss counters (binary saturating otherwise).
module press_game_core #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 2,
    parameter int SCORE_W   = 8,
    parameter int GARB_TTL  = 6
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               hit_n,
    input  logic [LANE_W-1:0]  rng,
    press_game_core_if.master  draw,
    output logic [LANE_W-1:0]  press_pos,
    output logic               garb_valid,
    output logic [LANE_W-1:0]  garb_pos,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] miss_count
);
    typedef enum logic [2:0] {IDLE, G_ERASE, P_ERASE, P_DRAW, G_DRAW} state_t;
    localparam logic [LANE_W-1:0] TOP = LANE_W'(NUM_LANES - 1);
    localparam logic [LANE_W-1:0] ONE = LANE_W'(1);

    state_t             state_q, state_d;
    logic [LANE_W-1:0]  press_q, press_d, prev_q, prev_d, gpos_q, gpos_d;
    logic [LANE_W-1:0]  epos_q, epos_d, dpos_q, dpos_d, lane;
    logic               up_q, up_d, gval_q, gval_d, hprev_q;
    logic               pp_q, pp_d, pgd_q, pgd_d, pge_q, pge_d;
    logic               req_q, req_d, item_q, item_d, ers_q, ers_d;
    logic [7:0]         ttl_q, ttl_d;
    logic [SCORE_W-1:0] score_q, score_d, miss_q, miss_d, miss_1;
    logic               hit_ev, hit_ok, expire, spawn, clear, ack, pp_keep, in_gd;

    function automatic logic [SCORE_W-1:0] inc(input logic [SCORE_W-1:0] x);
`ifdef SCORE_BCD_EN
        logic [SCORE_W-1:0] y;
        logic               c;
        y = x;
        c = 1'b1;
        for (int i = 0; i < SCORE_W / 4; i++) begin
            if (c && y[4*i +: 4] == 4'd9) begin
                y[4*i +: 4] = 4'd0;
            end else if (c) begin
                y[4*i +: 4] = y[4*i +: 4] + 4'd1;
                c = 1'b0;
            end
        end
        return c ? x : y;
`else
        return &x ? x : x + SCORE_W'(1);
`endif
    endfunction

    assign lane   = (32'(rng) < NUM_LANES) ? rng : LANE_W'(32'(rng) - 32'(NUM_LANES));
    assign hit_ev = hprev_q & ~hit_n;
    assign hit_ok = hit_ev & gval_q & (press_q == gpos_q);
    assign expire = tick & gval_q & (ttl_q == 8'd1) & ~hit_ok;
    assign spawn  = tick & ~gval_q;
    assign clear  = hit_ok | expire;
    assign ack    = req_q & draw.draw_ack;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        dpos_d  = dpos_q;
        item_d  = item_q;
        ers_d   = ers_q;
        if (ack) begin
            req_d   = 1'b0;
            state_d = (state_q == P_ERASE) ? P_DRAW : IDLE;
        end else if (state_q == P_DRAW && !req_q) begin
            req_d  = 1'b1;
            dpos_d = press_q;
            item_d = 1'b1;
            ers_d  = 1'b0;
        end else if (state_q == IDLE && (pge_q || pp_q || pgd_q)) begin
            req_d   = 1'b1;
            state_d = pge_q ? G_ERASE : pp_q ? P_ERASE : G_DRAW;
            dpos_d  = pge_q ? epos_q : pp_q ? prev_q : gpos_q;
            item_d  = ~pge_q & pp_q;
            ers_d   = pge_q | pp_q;
        end
    end

    always_comb begin
        pp_keep = pp_q & ~(ack & (state_q == P_ERASE));
        // A garbage draw already on the bus cannot be cancelled, so it must be erased instead.
        in_gd   = (state_q == G_DRAW) || (state_d == G_DRAW);
        press_d = !tick ? press_q
                : up_q  ? ((press_q == TOP) ? TOP - ONE : press_q + ONE)
                :         ((press_q == '0) ? ONE : press_q - ONE);
        up_d    = !tick ? up_q : up_q ? (press_q != TOP) : (press_q == '0);
        prev_d  = (tick & ~pp_keep) ? press_q : prev_q;
        pp_d    = tick | pp_keep;
        gval_d  = spawn ? 1'b1 : clear ? 1'b0 : gval_q;
        gpos_d  = spawn ? lane : gpos_q;
        ttl_d   = spawn ? 8'(GARB_TTL) : (tick & gval_q & ~clear) ? ttl_q - 8'd1 : ttl_q;
        epos_d  = clear ? gpos_q : epos_q;
        pge_d   = (clear & (~pgd_q | in_gd)) | (pge_q & ~(ack & (state_q == G_ERASE)));
        pgd_d   = spawn | (pgd_q & ~(clear & ~in_gd) & ~(ack & (state_q == G_DRAW)));
        score_d = hit_ok ? inc(score_q) : score_q;
        miss_1  = (hit_ev & ~hit_ok) ? inc(miss_q) : miss_q;
        miss_d  = expire ? inc(miss_1) : miss_1;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= IDLE;
            press_q <= '0;
            up_q    <= 1'b1;
            prev_q  <= '0;
            pp_q    <= 1'b0;
            gval_q  <= 1'b0;
            gpos_q  <= '0;
            ttl_q   <= '0;
            epos_q  <= '0;
            pge_q   <= 1'b0;
            pgd_q   <= 1'b0;
            score_q <= '0;
            miss_q  <= '0;
            hprev_q <= 1'b1;
            req_q   <= 1'b0;
            dpos_q  <= '0;
            item_q  <= 1'b0;
            ers_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            press_q <= press_d;
            up_q    <= up_d;
            prev_q  <= prev_d;
            pp_q    <= pp_d;
            gval_q  <= gval_d;
            gpos_q  <= gpos_d;
            ttl_q   <= ttl_d;
            epos_q  <= epos_d;
            pge_q   <= pge_d;
            pgd_q   <= pgd_d;
            score_q <= score_d;
            miss_q  <= miss_d;
            hprev_q <= hit_n;
            req_q   <= req_d;
            dpos_q  <= dpos_d;
            item_q  <= item_d;
            ers_q   <= ers_d;
        end
    end

    assign draw.draw_req   = req_q;
    assign draw.draw_pos   = dpos_q;
    assign draw.draw_item  = item_q;
    assign draw.draw_erase = ers_q;
    assign press_pos       = press_q;
    assign garb_valid      = gval_q;
    assign garb_pos        = gpos_q;
    assign score           = score_q;
    assign miss_count      = miss_q;
endmodule

// File: tb/tb_press_game_core.sv
// tb_press_game_core: directed scenarios against a game-rule model and an expected draw-command queue.
module tb_press_game_core;
    localparam int N = 5, LW = 3, SW = 8, TTL = 3;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b0;
    logic          tick     = 1'b0;
    logic          hit_n    = 1'b1;
    logic [LW-1:0] rng      = '0;
    logic [LW-1:0] press_pos, garb_pos;
    logic          garb_valid;
    logic [SW-1:0] score, miss_count;
    logic          auto_ack = 1'b1, auto_pulse = 1'b0, man_ack = 1'b0, cmp_en = 1'b0;

    int n_tests = 0, n_fail = 0;
    int m_phase = 0, m_gv = 0, m_gp = 0, m_life = 0, m_score = 0, m_miss = 0, m_hprev = 1;
    int exp_q[$];
    int log_q[$];
    int sweep_tab[8] = '{1, 2, 3, 4, 3, 2, 1, 0};

    press_game_core_if #(.LANE_W(LW)) bus ();

    press_game_core #(.NUM_LANES(N), .LANE_W(LW), .SCORE_W(SW), .GARB_TTL(TTL)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .tick       (tick),
        .hit_n      (hit_n),
        .rng        (rng),
        .draw       (bus),
        .press_pos  (press_pos),
        .garb_valid (garb_valid),
        .garb_pos   (garb_pos),
        .score      (score),
        .miss_count (miss_count)
    );

    assign bus.draw_ack = auto_pulse | man_ack;

    initial forever #10 CLOCK_50 = ~CLOCK_50;

    function automatic int sweep(input int k);
        return (k < N) ? k : 2 * N - 2 - k;
    endfunction

    function automatic int enc(input int pos, input int item, input int erase);
        return pos * 4 + item * 2 + erase;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_log(input string name, input int idx, input int expv);
        check(name, (idx >= 0 && idx < log_q.size()) ? log_q[idx] : 32'hFFFF_FFFF, expv);
    endtask

    // One clock cycle: apply inputs, advance the rule model, return at negedge+1.
    task automatic step(input bit t, input bit h, input int r, input bit rst = 1'b0);
        int  oldp;
        bit  fall, hit, spawn, clr;
        tick    = t;
        hit_n   = h;
        rng     = LW'(r);
        reset_n = ~rst;
        if (rst) begin
            m_phase = 0; m_gv = 0; m_gp = 0; m_life = 0;
            m_score = 0; m_miss = 0; m_hprev = 1;
            exp_q.delete();
        end else begin
            oldp  = sweep(m_phase);
            fall  = (m_hprev == 1) && !h;
            hit   = fall && m_gv == 1 && oldp == m_gp;
            spawn = t && m_gv == 0;
            clr   = hit;
            if (fall && !hit) m_miss++;
            if (hit) begin
                m_score++;
                m_gv = 0;
            end else if (t && m_gv == 1) begin
                m_life--;
                if (m_life == 0) begin
                    m_gv = 0;
                    m_miss++;
                    clr = 1'b1;
                end
            end
            if (clr) exp_q.push_back(enc(m_gp, 0, 1));
            if (t) begin
                m_phase = (m_phase + 1) % (2 * N - 2);
                exp_q.push_back(enc(oldp, 1, 1));
                exp_q.push_back(enc(sweep(m_phase), 1, 0));
            end
            if (spawn) begin
                m_gv   = 1;
                m_gp   = r % N;
                m_life = TTL;
                exp_q.push_back(enc(m_gp, 0, 0));
            end
            m_hprev = h;
            if (m_score > 255) m_score = 255;
            if (m_miss > 255) m_miss = 255;
        end
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 1, 0);
    endtask

    always @(negedge CLOCK_50) begin
        if (cmp_en) begin
            check("press_pos", press_pos, sweep(m_phase));
            check("garb_valid", garb_valid, m_gv);
            check("garb_pos", garb_pos, m_gp);
            check("score", score, m_score);
            check("miss_count", miss_count, m_miss);
        end
    end

    // Drawer: acknowledges each command three cycles after it appears and checks it against the queue.
    initial begin : drawer
        int c;
        forever begin
            @(negedge CLOCK_50);
            if (auto_ack && bus.draw_req) begin
                c = enc(int'(bus.draw_pos), int'(bus.draw_item), int'(bus.draw_erase));
                log_q.push_back(c);
                check("cmd_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("cmd", c, exp_q.pop_front());
                repeat (2) begin
                    @(negedge CLOCK_50);
                    check("cmd_hold", bus.draw_req ? enc(int'(bus.draw_pos), int'(bus.draw_item),
                          int'(bus.draw_erase)) : -1, c);
                end
                auto_pulse = 1'b1;
                @(negedge CLOCK_50);
                auto_pulse = 1'b0;
                check("req_gap", bus.draw_req, 0);
            end
        end
    end

    initial begin
        cmp_en = 1'b1;
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        check("rst_press", press_pos, 0);
        check("rst_gv", garb_valid, 0);
        check("rst_score", score, 0);
        check("rst_miss", miss_count, 0);
        check("rst_req", bus.draw_req, 0);
        idle(2);
        for (int k = 0; k < 8; k++) begin
            step(1, 1, (k == 0) ? 6 : 2);
            check("sweep_lit", press_pos, sweep_tab[k]);
            if (k == 0) begin
                check("spawn_rng6_pos", garb_pos, 1);
                check("spawn_rng6_gv", garb_valid, 1);
            end
            if (k == 3) begin
                check("expire_gv", garb_valid, 0);
                check("expire_miss", miss_count, 1);
            end
            if (k == 4) begin
                check("respawn_gv", garb_valid, 1);
                check("respawn_pos", garb_pos, 2);
            end
            idle(20);
        end
        check("sweep_miss2", miss_count, 2);
        check_log("log_perase0", 0, enc(0, 1, 1));
        check_log("log_pdraw1", 1, enc(1, 1, 0));
        check_log("log_gdraw1", 2, enc(1, 0, 0));
        check_log("log_gerase1", 7, enc(1, 0, 1));
        check("drain_a", exp_q.size(), 0);

        step(0, 1, 0, 1);
        idle(2);
        step(1, 1, 2);
        idle(20);
        step(1, 1, 0);
        idle(20);
        check("hit_press", press_pos, 2);
        step(0, 0, 0);
        check("hit_score", score, 1);
        check("hit_gv", garb_valid, 0);
        repeat (4) step(0, 0, 0);
        idle(20);
        check_log("hit_gerase2", log_q.size() - 1, enc(2, 0, 1));
        step(1, 1, 4);
        check("hit_respawn_gv", garb_valid, 1);
        check("hit_respawn_pos", garb_pos, 4);
        idle(20);
        repeat (20) step(0, 0, 0);
        step(0, 1, 0);
        check("hold_miss_once", miss_count, 1);
        idle(10);
        step(1, 1, 0);
        idle(20);
        step(1, 0, 0);
        check("same_cyc_score", score, 2);
        check("same_cyc_gv", garb_valid, 0);
        check("same_cyc_press", press_pos, 3);
        idle(20);
        check_log("same_cyc_gerase", log_q.size() - 3, enc(4, 0, 1));
        step(1, 1, 1);
        check("late_spawn_gv", garb_valid, 1);
        check("late_spawn_pos", garb_pos, 1);
        idle(20);
        check("drain_b", exp_q.size(), 0);

        step(0, 1, 0, 1);
        repeat (260) begin
            step(0, 0, 0);
            step(0, 1, 0);
        end
        check("miss_sat", miss_count, 255);

        step(0, 1, 0, 1);
        idle(2);
        auto_ack = 1'b0;
        step(1, 1, 3);
        for (int i = 0; i < 10 && !bus.draw_req; i++) step(0, 1, 0);
        check("midcmd_req_seen", bus.draw_req, 1);
        check("midcmd_item", bus.draw_item, 1);
        step(0, 1, 0, 1);
        check("midrst_req", bus.draw_req, 0);
        check("midrst_pos", bus.draw_pos, 0);
        check("midrst_item", bus.draw_item, 0);
        check("midrst_erase", bus.draw_erase, 0);
        check("midrst_press", press_pos, 0);
        man_ack = 1'b1;
        step(0, 1, 0);
        man_ack = 1'b0;
        idle(5);
        check("late_ack_req", bus.draw_req, 0);
        check("late_ack_press", press_pos, 0);
        check("late_ack_gv", garb_valid, 0);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
